// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU control path: state encoding,
// array geometry and the ceil(x/4) helper used for tile counts.
package tpu_pkg;

   localparam int SA_SIZE     = 4;
   localparam int WAIT_CYCLES = 2 * SA_SIZE - 1;
   localparam int ADDR_W      = 8;
   localparam int DIM_W       = 4;
   localparam int CNT_W       = 4;
   localparam int TILE_W      = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_e;

   // Number of 4-wide tiles covering x; 0..4 for a 4-bit dimension.
   function automatic logic [2:0] ceil_div4(input logic [DIM_W-1:0] x);
      logic [DIM_W:0] s;
      s = {1'b0, x} + (DIM_W + 1)'(3);
      return s[DIM_W:2];
   endfunction

endpackage

// File: rtl/tpu_ctrl_if.sv
// Command and buffer/array strobe bundle between the TPU sequencer (master)
// and the host plus global buffers (slave).
interface tpu_ctrl_if import tpu_pkg::*; ;

   logic              start;
   logic [DIM_W-1:0]  m;
   logic [DIM_W-1:0]  k;
   logic [DIM_W-1:0]  n;
   logic              done;
   logic              busy;
   logic              gbuff_a_rd;
   logic [ADDR_W-1:0] gbuff_a_addr;
   logic              gbuff_b_rd;
   logic [ADDR_W-1:0] gbuff_b_addr;
   logic              sa_clear;
   logic              sa_valid;
   logic [1:0]        sa_row_sel;
   logic              gbuff_out_wr;
   logic [ADDR_W-1:0] gbuff_out_addr;

   modport master (
      input  start, m, k, n,
      output done, busy, gbuff_a_rd, gbuff_a_addr, gbuff_b_rd, gbuff_b_addr,
             sa_clear, sa_valid, sa_row_sel, gbuff_out_wr, gbuff_out_addr
   );

   modport slave (
      output start, m, k, n,
      input  done, busy, gbuff_a_rd, gbuff_a_addr, gbuff_b_rd, gbuff_b_addr,
             sa_clear, sa_valid, sa_row_sel, gbuff_out_wr, gbuff_out_addr
   );

endinterface

// File: rtl/tpu_tile_cnt.sv
// Nested output-tile counter: nt runs fastest, mt advances when nt wraps.
// last_o flags the final tile of the job.
module tpu_tile_cnt import tpu_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              adv_i,
   input  logic [TILE_W-1:0] nt_max_i,
   input  logic [TILE_W-1:0] mt_max_i,
   output logic [TILE_W-1:0] nt_o,
   output logic [TILE_W-1:0] mt_o,
   output logic              last_o
);

   logic [TILE_W-1:0] nt_q, nt_d;
   logic [TILE_W-1:0] mt_q, mt_d;

   assign last_o = (nt_q == nt_max_i) && (mt_q == mt_max_i);
   assign nt_o   = nt_q;
   assign mt_o   = mt_q;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      nt_d = nt_q;
      mt_d = mt_q;
      if (clr_i) begin
         nt_d = '0;
         mt_d = '0;
      end else if (adv_i) begin
         if (nt_q < nt_max_i) begin
            nt_d = nt_q + TILE_W'(1);
         end else begin
            nt_d = '0;
            mt_d = last_o ? '0 : mt_q + TILE_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nt_q <= '0;
         mt_q <= '0;
      end else begin
         nt_q <= nt_d;
         mt_q <= mt_d;
      end
   end

endmodule

// File: rtl/tpu_ctrl.sv
// TPU main sequencer: per 4x4 output tile runs CLEAR, FEED, WAIT, DRAIN and
// owns all global-buffer addressing. Optional TPU_CTRL_PERF_EN adds perf_cycles.
module tpu_ctrl import tpu_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   tpu_ctrl_if.master bus
`ifdef TPU_CTRL_PERF_EN
   ,
   output logic [15:0] perf_cycles
`endif
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIM_W-1:0]  m_q, k_q, n_q;
   logic              sa_valid_q;
   logic              accept, tile_adv, busy_w;
   logic [TILE_W-1:0] nt, mt;
   logic              last_tile;
   logic [2:0]        n_tiles;
   logic [DIM_W-1:0]  row;

   assign n_tiles = ceil_div4(n_q);
   assign row     = {mt, 2'b00} + DIM_W'(cnt_q[1:0]);

   tpu_tile_cnt u_tile_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (accept),
      .adv_i    (tile_adv),
      .nt_max_i (TILE_W'(n_tiles - 3'd1)),
      .mt_max_i (TILE_W'(ceil_div4(m_q) - 3'd1)),
      .nt_o     (nt),
      .mt_o     (mt),
      .last_o   (last_tile)
   );

   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      accept             = 1'b0;
      tile_adv           = 1'b0;
      busy_w             = 1'b0;
      bus.done           = 1'b0;
      bus.gbuff_a_rd     = 1'b0;
      bus.gbuff_a_addr   = '0;
      bus.gbuff_b_rd     = 1'b0;
      bus.gbuff_b_addr   = '0;
      bus.sa_clear       = 1'b0;
      bus.sa_row_sel     = '0;
      bus.gbuff_out_wr   = 1'b0;
      bus.gbuff_out_addr = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = (bus.m == '0 || bus.k == '0 || bus.n == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy_w       = 1'b1;
            bus.sa_clear = 1'b1;
            cnt_d        = '0;
            state_d      = S_FEED;
         end
         S_FEED: begin
            busy_w           = 1'b1;
            bus.gbuff_a_rd   = 1'b1;
            bus.gbuff_b_rd   = 1'b1;
            bus.gbuff_a_addr = ADDR_W'(mt) * ADDR_W'(k_q) + ADDR_W'(cnt_q);
            bus.gbuff_b_addr = ADDR_W'(nt) * ADDR_W'(k_q) + ADDR_W'(cnt_q);
            if (cnt_q == k_q - DIM_W'(1)) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            busy_w = 1'b1;
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            busy_w             = 1'b1;
            bus.sa_row_sel     = cnt_q[1:0];
            // Rows past m in the last row-tile are padding and must not be written.
            bus.gbuff_out_wr   = (row < m_q);
            bus.gbuff_out_addr = ADDR_W'(row) * ADDR_W'(n_tiles) + ADDR_W'(nt);
            if (cnt_q == CNT_W'(SA_SIZE - 1)) begin
               cnt_d    = '0;
               tile_adv = 1'b1;
               state_d  = last_tile ? S_DONE : S_CLEAR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            // Stay here while start is held so a level start cannot retrigger.
            if (!bus.start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy     = busy_w;
   assign bus.sa_valid = sa_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         m_q        <= '0;
         k_q        <= '0;
         n_q        <= '0;
         sa_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sa_valid_q <= bus.gbuff_a_rd;
         if (accept) begin
            m_q <= bus.m;
            k_q <= bus.k;
            n_q <= bus.n;
         end
      end
   end

`ifdef TPU_CTRL_PERF_EN
   logic [15:0] perf_q;

   // The accept cycle itself is counted, so the figure spans start to done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_q <= '0;
      end else if (accept) begin
         perf_q <= 16'd1;
      end else if (busy_w && perf_q != 16'hFFFF) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for tpu_ctrl: cycle-exact strobes for a single tile, row
// masking on a ragged job, zero-dimension jobs, held start and mid-job reset.
module tb_tpu_ctrl;
   import tpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tpu_ctrl_if bus ();
`ifdef TPU_CTRL_PERF_EN
   logic [15:0] perf_cycles;
`endif

   tpu_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef TPU_CTRL_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // Strobe monitor, sampled mid-cycle.
   int n_rd_a = 0;
   int n_rd_b = 0;
   int n_excl = 0;
   logic [ADDR_W-1:0] wr_q[$];

   always @(negedge clk) begin
      if (bus.gbuff_a_rd) n_rd_a++;
      if (bus.gbuff_b_rd) n_rd_b++;
      if (bus.gbuff_out_wr) wr_q.push_back(bus.gbuff_out_addr);
      if (int'(bus.gbuff_a_rd | bus.gbuff_b_rd) + int'(bus.gbuff_out_wr) + int'(bus.sa_clear) > 1)
         n_excl++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.done, bus.busy, bus.gbuff_a_rd, bus.gbuff_a_addr, bus.gbuff_b_rd,
                  bus.gbuff_b_addr, bus.sa_clear, bus.sa_valid, bus.sa_row_sel,
                  bus.gbuff_out_wr, bus.gbuff_out_addr});
   endfunction

   task automatic run_until_done(input int budget, output int cycles);
      cycles = 0;
      while (!bus.done && cycles < budget) begin
         tick();
         cycles++;
      end
      check("done_within_budget", 64'(bus.done), 64'd1);
   endtask

   int base_w, base_a, base_b, cyc, idx;

   initial begin
      bus.start = 1'b0;
      bus.m = '0;
      bus.k = '0;
      bus.n = '0;
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      check("idle_outputs", all_outs(), 64'd0);

      // ---- Job 1: m=k=n=4, one tile; start in cycle 0 ----
      base_w = wr_q.size(); base_a = n_rd_a; base_b = n_rd_b;
      bus.m = 4'd4; bus.k = 4'd4; bus.n = 4'd4;
      bus.start = 1'b1;
      tick();                                            // cycle 1: CLEAR
      check("c1_clear", 64'(bus.sa_clear), 64'd1);
      check("c1_busy", 64'(bus.busy), 64'd1);
      check("c1_no_rd", 64'(bus.gbuff_a_rd), 64'd0);
      for (int i = 0; i < 4; i++) begin                  // cycles 2..5: FEED
         tick();
         check("feed_a_rd", 64'(bus.gbuff_a_rd), 64'd1);
         check("feed_a_addr", 64'(bus.gbuff_a_addr), 64'(i));
         check("feed_b_addr", 64'(bus.gbuff_b_addr), 64'(i));
         check("feed_sa_valid", 64'(bus.sa_valid), (i == 0) ? 64'd0 : 64'd1);
      end
      tick();                                            // cycle 6: WAIT
      check("wait_rd_off", 64'(bus.gbuff_a_rd | bus.gbuff_b_rd), 64'd0);
      check("wait_valid_tail", 64'(bus.sa_valid), 64'd1);
      repeat (6) tick();                                 // cycle 12: last WAIT
      check("wait_end_quiet", 64'({bus.sa_valid, bus.gbuff_out_wr}), 64'd0);
      for (int r = 0; r < 4; r++) begin                  // cycles 13..16: DRAIN
         tick();
         check("drain_wr", 64'(bus.gbuff_out_wr), 64'd1);
         check("drain_addr", 64'(bus.gbuff_out_addr), 64'(r));
         check("drain_row_sel", 64'(bus.sa_row_sel), 64'(r));
      end
      tick();                                            // cycle 17: DONE
      check("c17_done", 64'(bus.done), 64'd1);
      check("c17_busy", 64'(bus.busy), 64'd0);
`ifdef TPU_CTRL_PERF_EN
      check("perf_cycles", 64'(perf_cycles), 64'd17);
`endif
      check("j1_wr_count", 64'(wr_q.size() - base_w), 64'd4);
      check("j1_rd_a_count", 64'(n_rd_a - base_a), 64'd4);
      check("j1_rd_b_count", 64'(n_rd_b - base_b), 64'd4);

      // Held start must not retrigger.
      repeat (5) tick();
      check("held_done", 64'(bus.done), 64'd1);
      check("held_no_reads", 64'(n_rd_a - base_a), 64'd4);
      bus.start = 1'b0;
      tick();
      check("release_done_low", 64'(bus.done), 64'd0);

      // Rerun the same job: identical OUT address stream and timing.
      base_w = wr_q.size();
      bus.start = 1'b1;
      run_until_done(40, cyc);
      check("rerun_latency", 64'(cyc), 64'd17);
      check("rerun_wr_count", 64'(wr_q.size() - base_w), 64'd4);
      for (int i = 0; i < 4; i++)
         check("rerun_wr_addr", 64'(wr_q[base_w + i]), 64'(i));
      bus.start = 1'b0;
      tick();

      // ---- Job 2: m=5 k=3 n=9, 2x3 tiles with masked rows ----
      base_w = wr_q.size(); base_a = n_rd_a;
      bus.m = 4'd5; bus.k = 4'd3; bus.n = 4'd9;
      bus.start = 1'b1;
      tick();
      bus.m = 4'd15; bus.k = 4'd15; bus.n = 4'd15;       // ignored once latched
      run_until_done(200, cyc);
      check("j2_latency", 64'(cyc + 1), 64'd91);         // 6 tiles x 15 + 1
      check("j2_wr_count", 64'(wr_q.size() - base_w), 64'd15);
      check("j2_rd_count", 64'(n_rd_a - base_a), 64'd18);
      idx = 0;
      for (int mt = 0; mt < 2; mt++)
         for (int nt = 0; nt < 3; nt++)
            for (int r = 0; r < 4; r++)
               if (mt * 4 + r < 5) begin
                  check("j2_wr_addr", 64'(wr_q[base_w + idx]), 64'((mt * 4 + r) * 3 + nt));
                  idx++;
               end
      check("j2_last_wr", 64'(wr_q[wr_q.size() - 1]), 64'd14);
      bus.start = 1'b0;
      tick();

      // ---- Job 3: k=0 finishes with no traffic ----
      base_w = wr_q.size(); base_a = n_rd_a; base_b = n_rd_b;
      bus.m = 4'd4; bus.k = 4'd0; bus.n = 4'd4;
      bus.start = 1'b1;
      run_until_done(2, cyc);
      check("k0_latency", 64'(cyc), 64'd1);
      check("k0_busy", 64'(bus.busy), 64'd0);
      repeat (2) tick();
      check("k0_no_traffic", 64'((n_rd_a - base_a) + (n_rd_b - base_b) + (wr_q.size() - base_w)), 64'd0);
      bus.start = 1'b0;
      tick();

      // ---- Job 4: reset during WAIT of the second tile, then clean rerun ----
      bus.m = 4'd4; bus.k = 4'd4; bus.n = 4'd8;
      bus.start = 1'b1;
      repeat (24) tick();                                // cycle 24: tile 1 WAIT
      check("j4_in_wait", 64'({bus.busy, bus.gbuff_a_rd, bus.gbuff_out_wr}), 64'b100);
      #2 rst = 1'b0;
      #1;
      check("async_reset_outs", all_outs(), 64'd0);
      bus.start = 1'b0;
      tick();
      check("reset_held_outs", all_outs(), 64'd0);
      rst = 1'b1;
      tick();
      base_w = wr_q.size();
      bus.start = 1'b1;
      tick();
      check("j4_restart_clear", 64'(bus.sa_clear), 64'd1);
      tick();
      check("j4_tile0_addr", 64'({bus.gbuff_a_addr, bus.gbuff_b_addr}), 64'd0);
      run_until_done(60, cyc);
      check("j4_latency", 64'(cyc + 2), 64'd33);
      check("j4_wr_count", 64'(wr_q.size() - base_w), 64'd8);
      for (int nt = 0; nt < 2; nt++)
         for (int r = 0; r < 4; r++)
            check("j4_wr_addr", 64'(wr_q[base_w + nt * 4 + r]), 64'(r * 2 + nt));
      bus.start = 1'b0;
      tick();

      check("strobe_exclusive", 64'(n_excl), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
